// File: rtl/zigbee_pkg.sv
// Shared constants, types and helpers for the 802.15.4 O-QPSK chip despreader.
package zigbee_pkg;

    localparam int unsigned CHIPS    = 32;
    localparam int unsigned NUM_SYMS = 16;
    localparam int unsigned SYM_W    = 4;
    localparam int unsigned DIST_W   = 6;
    localparam int unsigned CC_W     = 5;
    localparam int unsigned CNT_W    = 4;

    // Bit i holds chip c_i, so c0 (first on air) is the LSB.
    localparam logic [CHIPS-1:0] SYM0     = 32'h744A_C39B;
    localparam logic [CHIPS-1:0] ODD_MASK = 32'hAAAA_AAAA;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD
    } dsp_state_e;

    // Chip sequence of a symbol: a right shift on air is a left rotate of the vector.
    function automatic logic [CHIPS-1:0] chip_seq(input logic [SYM_W-1:0] sym);
        logic [2*CHIPS-1:0] dbl;
        logic [CHIPS-1:0]   seq;
        dbl = {SYM0, SYM0} << {sym[2:0], 2'b00};
        seq = dbl[2*CHIPS-1:CHIPS];
        if (sym[3]) begin
            seq = seq ^ ODD_MASK;
        end
        return seq;
    endfunction

    function automatic logic [DIST_W-1:0] popcount(input logic [CHIPS-1:0] v);
        logic [DIST_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHIPS; i++) begin
            n = n + DIST_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/chip_despreader_if.sv
// Chip input and symbol output bundle between cdr, despreader and MAC front end.
interface chip_despreader_if;
    import zigbee_pkg::*;

    logic             i_chip;
    logic             i_chip_flag;
    logic             i_clear;
    logic [SYM_W-1:0] o_symbol;
    logic             o_sym_flag;
    logic             o_sym_err;
    logic             o_sfd;
    logic             o_sync;

    modport master (
        output i_chip, i_chip_flag, i_clear,
        input  o_symbol, o_sym_flag, o_sym_err, o_sfd, o_sync
    );

    modport slave (
        input  i_chip, i_chip_flag, i_clear,
        output o_symbol, o_sym_flag, o_sym_err, o_sfd, o_sync
    );

endinterface

// File: rtl/chip_correlator.sv
// Combinational 16-way Hamming correlator: best symbol, its distance, and distance to SYM0.
module chip_correlator
    import zigbee_pkg::*;
(
    input  logic [CHIPS-1:0]  win_i,
    output logic [SYM_W-1:0]  best_idx_c_o,
    output logic [DIST_W-1:0] best_dist_c_o,
    output logic [DIST_W-1:0] dist0_c_o
);

    logic [DIST_W-1:0] dist_c;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx_c_o  = '0;
        best_dist_c_o = DIST_W'(CHIPS);
        dist0_c_o     = '0;
        dist_c        = '0;
        for (int k = 0; k < NUM_SYMS; k++) begin
            dist_c = popcount(win_i ^ chip_seq(SYM_W'(k)));
            if (k == 0) begin
                dist0_c_o = dist_c;
            end
            if (dist_c < best_dist_c_o) begin
                best_dist_c_o = dist_c;
                best_idx_c_o  = SYM_W'(k);
            end
        end
    end

endmodule

// File: rtl/chip_despreader.sv
// Chip-stream despreader: preamble alignment, SFD detection and per-block symbol decisions.
module chip_despreader
    import zigbee_pkg::*;
#(
    parameter int unsigned SYNC_THRESH   = 4,
    parameter int unsigned SYM_THRESH    = 8,
    parameter int unsigned PREAMBLE_SYMS = 2,
    parameter int unsigned MAX_ERRS      = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    chip_despreader_if.slave   bus
);

    dsp_state_e        state_q, state_d;
    logic [CHIPS-1:0]  win_q, win_d;
    logic              chip_vld_q;
    logic [CC_W-1:0]   chip_cnt_q, chip_cnt_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic              sym_flag_q, sym_flag_d;
    logic              sym_err_q, sym_err_d;
    logic              sfd_q, sfd_d;
    logic              sync_q, sync_d;

    logic              accept_c;
    logic [SYM_W-1:0]  best_idx_c;
    logic [DIST_W-1:0] best_dist_c;
    logic [DIST_W-1:0] dist0_c;
    logic              good_c;
    logic              block_end_c;

    // A clear in the same cycle as a chip discards that chip.
    assign accept_c    = bus.i_chip_flag & ~bus.i_clear;
    assign good_c      = (best_dist_c <= DIST_W'(SYM_THRESH));
    assign block_end_c = (chip_cnt_q == CC_W'(CHIPS - 1));

    always_comb begin
        win_d = win_q;
        if (accept_c) begin
            win_d = {bus.i_chip, win_q[CHIPS-1:1]};
        end
    end

    chip_correlator u_corr (
        .win_i         (win_q),
        .best_idx_c_o  (best_idx_c),
        .best_dist_c_o (best_dist_c),
        .dist0_c_o     (dist0_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_SEARCH;
            win_q      <= '0;
            chip_vld_q <= 1'b0;
            chip_cnt_q <= '0;
            pre_cnt_q  <= '0;
            err_cnt_q  <= '0;
            sym_q      <= '0;
            sym_flag_q <= 1'b0;
            sym_err_q  <= 1'b0;
            sfd_q      <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            chip_vld_q <= accept_c;
            chip_cnt_q <= chip_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            err_cnt_q  <= err_cnt_d;
            sym_q      <= sym_d;
            sym_flag_q <= sym_flag_d;
            sym_err_q  <= sym_err_d;
            sfd_q      <= sfd_d;
            sync_q     <= sync_d;
        end
    end

    // Decision stage: acts one edge after a chip lands in the window.
    always_comb begin
        state_d    = state_q;
        chip_cnt_d = chip_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        err_cnt_d  = err_cnt_q;
        sym_d      = sym_q;
        sym_err_d  = sym_err_q;
        sym_flag_d = 1'b0;
        sfd_d      = 1'b0;
        // Sync lags the state by one cycle so it drops after the exit strobe.
        sync_d     = (state_q == ST_PAYLOAD);

        if (bus.i_clear) begin
            state_d    = ST_SEARCH;
            chip_cnt_d = '0;
            pre_cnt_d  = '0;
            err_cnt_d  = '0;
            sync_d     = 1'b0;
        end else if (chip_vld_q) begin
            case (state_q)
                ST_SEARCH: begin
                    if (dist0_c <= DIST_W'(SYNC_THRESH)) begin
                        state_d    = ST_PREAMBLE;
                        chip_cnt_d = '0;
                        pre_cnt_d  = CNT_W'(1);
                    end
                end
                ST_PREAMBLE: begin
                    chip_cnt_d = chip_cnt_q + CC_W'(1);
                    if (block_end_c) begin
                        if (good_c && best_idx_c == SYM_W'(0)) begin
                            if (pre_cnt_q < CNT_W'(PREAMBLE_SYMS)) begin
                                pre_cnt_d = pre_cnt_q + CNT_W'(1);
                            end
                        end else if (good_c && best_idx_c == SYM_W'(7) &&
                                     pre_cnt_q >= CNT_W'(PREAMBLE_SYMS)) begin
                            state_d = ST_SFD;
                        end else begin
                            state_d    = ST_SEARCH;
                            chip_cnt_d = '0;
                            pre_cnt_d  = '0;
                        end
                    end
                end
                ST_SFD: begin
                    chip_cnt_d = chip_cnt_q + CC_W'(1);
                    if (block_end_c) begin
                        pre_cnt_d = '0;
                        err_cnt_d = '0;
                        if (good_c && best_idx_c == SYM_W'(10)) begin
                            state_d = ST_PAYLOAD;
                            sfd_d   = 1'b1;
                            sync_d  = 1'b1;
                        end else begin
                            state_d    = ST_SEARCH;
                            chip_cnt_d = '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    chip_cnt_d = chip_cnt_q + CC_W'(1);
                    if (block_end_c) begin
                        sym_d      = best_idx_c;
                        sym_err_d  = ~good_c;
                        sym_flag_d = 1'b1;
                        if (good_c) begin
                            err_cnt_d = '0;
                        end else if (err_cnt_q + CNT_W'(1) >= CNT_W'(MAX_ERRS)) begin
                            state_d    = ST_SEARCH;
                            chip_cnt_d = '0;
                            err_cnt_d  = '0;
                        end else begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    assign bus.o_symbol   = sym_q;
    assign bus.o_sym_flag = sym_flag_q;
    assign bus.o_sym_err  = sym_err_q;
    assign bus.o_sfd      = sfd_q;
    assign bus.o_sync     = sync_q;

endmodule

// File: tb/tb_chip_despreader.sv
// Directed bench for chip_despreader: frames built from the on-air chip string, table-driven payload.
module tb_chip_despreader;
    import zigbee_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chip_despreader_if bus ();

    chip_despreader dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // c0 is the MSB here, written in on-air order.
    localparam logic [31:0] TB_SYM0_STR = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

    typedef struct {
        int         sym;
        int         mode;
        logic [3:0] exp_sym;
        logic       exp_err;
        logic       exp_sync;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    int          sfd_cnt = 0;
    logic [3:0]  last_sym = '0;
    logic        last_err = 1'b0;
    logic        sync_at_sfd = 1'b0;
    logic [31:0] shadow_win = '0;
    vec_t        vecs [10];

    always @(negedge clk) begin
        if (bus.o_sym_flag) begin
            strobe_cnt <= strobe_cnt + 1;
            last_sym   <= bus.o_symbol;
            last_err   <= bus.o_sym_err;
        end
        if (bus.o_sfd) begin
            sfd_cnt     <= sfd_cnt + 1;
            sync_at_sfd <= bus.o_sync;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic tb_chip(input int k, input int i);
        logic [31:0] s;
        int          j;
        logic        c;
        s = TB_SYM0_STR;
        j = (i - 4 * (k % 8) + 32) % 32;
        c = s[31-j];
        if (k >= 8 && (i % 2) == 1) c = ~c;
        return c;
    endfunction

    task automatic send_chip(input logic c);
        bus.i_chip      = c;
        bus.i_chip_flag = 1'b1;
        @(posedge clk);
        #1;
        bus.i_chip_flag = 1'b0;
        shadow_win      = {c, shadow_win[31:1]};
    endtask

    // mode 0 clean, 1 three flipped chips, 2 keep only the first four ones (12 flips on SYM0)
    task automatic send_block(input int k, input int mode);
        int   ones;
        logic c;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            c = tb_chip(k, i);
            if (mode == 1 && (i == 3 || i == 14 || i == 25)) c = ~c;
            if (mode == 2 && c == 1'b1) begin
                ones++;
                if (ones > 4) c = 1'b0;
            end
            send_chip(c);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_preamble(input int n_sym0, input int sfd_hi);
        for (int n = 0; n < n_sym0; n++) send_block(0, 0);
        send_block(7, 0);
        send_block(sfd_hi, 0);
    endtask

    initial begin
        int base_s;
        int base_f;

        vecs[0] = '{3,  0, 4'h3, 1'b0, 1'b1};
        vecs[1] = '{12, 0, 4'hC, 1'b0, 1'b1};
        vecs[2] = '{15, 0, 4'hF, 1'b0, 1'b1};
        vecs[3] = '{5,  1, 4'h5, 1'b0, 1'b1};
        vecs[4] = '{9,  1, 4'h9, 1'b0, 1'b1};
        vecs[5] = '{14, 1, 4'hE, 1'b0, 1'b1};
        vecs[6] = '{0,  2, 4'h0, 1'b1, 1'b1};
        vecs[7] = '{6,  0, 4'h6, 1'b0, 1'b1};
        vecs[8] = '{0,  2, 4'h0, 1'b1, 1'b1};
        vecs[9] = '{0,  2, 4'h0, 1'b1, 1'b0};

        bus.i_chip      = 1'b0;
        bus.i_chip_flag = 1'b0;
        bus.i_clear     = 1'b0;
        rst             = 1'b1;
        idle(3);
        check("rst symbol", 32'(bus.o_symbol), 0);
        check("rst flag",   32'(bus.o_sym_flag), 0);
        check("rst err",    32'(bus.o_sym_err), 0);
        check("rst sfd",    32'(bus.o_sfd), 0);
        check("rst sync",   32'(bus.o_sync), 0);
        rst = 1'b0;
        idle(2);

        // Join mid-preamble: tail of a SYM0 block, then a full frame.
        base_f = sfd_cnt;
        for (int i = 19; i < 32; i++) send_chip(tb_chip(0, i));
        send_preamble(8, 10);
        idle(3);
        check("frame sfd count", 32'(sfd_cnt - base_f), 1);
        check("frame sync", 32'(bus.o_sync), 1);
        check("sync with sfd", 32'(sync_at_sfd), 1);

        for (int v = 0; v < 10; v++) begin
            base_s = strobe_cnt;
            send_block(vecs[v].sym, vecs[v].mode);
            idle(3);
            check($sformatf("vec%0d strobes", v), 32'(strobe_cnt - base_s), 1);
            check($sformatf("vec%0d symbol", v), 32'(last_sym), 32'(vecs[v].exp_sym));
            check($sformatf("vec%0d err", v), 32'(last_err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d sync", v), 32'(bus.o_sync), 32'(vecs[v].exp_sync));
        end
        check("state after loss", 32'(dut.state_q), 32'(ST_SEARCH));

        // One SYM0 only before the SFD.
        base_s = strobe_cnt; base_f = sfd_cnt;
        send_preamble(1, 10);
        send_block(3, 0);
        idle(3);
        check("short pre sfd", 32'(sfd_cnt - base_f), 0);
        check("short pre strobes", 32'(strobe_cnt - base_s), 0);
        check("short pre sync", 32'(bus.o_sync), 0);

        // Second SFD nibble 0xB instead of 0xA.
        base_s = strobe_cnt; base_f = sfd_cnt;
        send_preamble(4, 11);
        send_block(3, 0);
        idle(3);
        check("bad sfd sfd", 32'(sfd_cnt - base_f), 0);
        check("bad sfd strobes", 32'(strobe_cnt - base_s), 0);
        check("bad sfd sync", 32'(bus.o_sync), 0);

        // Clear coinciding with a chip flag mid-payload.
        base_f = sfd_cnt;
        send_preamble(4, 10);
        send_block(5, 0);
        idle(3);
        check("clr sfd", 32'(sfd_cnt - base_f), 1);
        check("clr pre symbol", 32'(last_sym), 5);
        base_s = strobe_cnt;
        for (int i = 0; i < 20; i++) send_chip(tb_chip(13, i));
        bus.i_chip      = ~tb_chip(13, 20);
        bus.i_chip_flag = 1'b1;
        bus.i_clear     = 1'b1;
        @(posedge clk);
        #1;
        bus.i_chip_flag = 1'b0;
        bus.i_clear     = 1'b0;
        check("clr sync", 32'(bus.o_sync), 0);
        check("clr window", dut.win_q, shadow_win);
        for (int i = 21; i < 32; i++) send_chip(tb_chip(13, i));
        send_block(13, 0);
        idle(3);
        check("clr strobes", 32'(strobe_cnt - base_s), 0);

        // Reset on the decision edge of a payload block, flags back-to-back.
        base_f = sfd_cnt;
        send_preamble(4, 10);
        send_block(9, 0);
        idle(3);
        check("rst2 sfd", 32'(sfd_cnt - base_f), 1);
        check("rst2 pre symbol", 32'(last_sym), 9);
        base_s = strobe_cnt;
        send_block(6, 0);
        bus.i_chip      = 1'b1;
        bus.i_chip_flag = 1'b1;
        rst             = 1'b1;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.i_chip_flag = 1'b0;
        shadow_win      = '0;
        check("rst2 symbol", 32'(bus.o_symbol), 0);
        check("rst2 flag",   32'(bus.o_sym_flag), 0);
        check("rst2 err",    32'(bus.o_sym_err), 0);
        check("rst2 sfd",    32'(bus.o_sfd), 0);
        check("rst2 sync",   32'(bus.o_sync), 0);
        idle(3);
        check("rst2 strobes", 32'(strobe_cnt - base_s), 0);

        base_f = sfd_cnt;
        send_preamble(4, 10);
        send_block(12, 0);
        idle(3);
        check("reacq sfd", 32'(sfd_cnt - base_f), 1);
        check("reacq symbol", 32'(last_sym), 32'hC);
        check("reacq err", 32'(last_err), 0);
        check("reacq sync", 32'(bus.o_sync), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
